// File: rtl/syn_update_scheduler.sv
// Sweeps every synapse word (pre-neuron p, word w) as a read/write pair so the
// synaptic core can apply a training update to each word of the synaptic SRAM.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for an accepted start (training on, config gate low)
// PRE_FETCH | request spike count of pre-neuron p
// RD        | read word p*WORDS+w, request post counts at w*POST_NEUR_PARALLEL
// WR        | write back the same word with the update qualifier raised
// DONE      | one-cycle completion pulse
module syn_update_scheduler #(
   parameter int INPUT_NEURON         = 784,
   parameter int OUTPUT_NEURON        = 256,
   parameter int POST_NEUR_PARALLEL   = 4,
   parameter int SYN_ARRAY_ADDR_WIDTH = 16,
   parameter int PRE_NEUR_ADDR_WIDTH  = 10,
   parameter int POST_NEUR_ADDR_WIDTH = 10
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            IS_TRAIN,
   input  logic                            SPI_GATE_ACTIVITY_sync,
   input  logic                            UPD_START,
   output logic                            UPD_BUSY,
   output logic                            UPD_DONE,
   output logic                            CTRL_SYNARRAY_CS,
   output logic                            CTRL_SYNARRAY_WE,
   output logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_SYNARRAY_ADDR,
   output logic                            CTRL_TREF_EVENT,
   output logic                            CTRL_PRE_CNT_RD,
   output logic [PRE_NEUR_ADDR_WIDTH-1:0]  CTRL_PRE_NEURON_ADDRESS,
   output logic                            CTRL_POST_CNT_RD,
   output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS
);

   localparam int WORDS   = OUTPUT_NEURON / POST_NEUR_PARALLEL;
   localparam int W_WIDTH = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [W_WIDTH-1:0]             W_LAST = W_WIDTH'(WORDS - 1);
   localparam logic [PRE_NEUR_ADDR_WIDTH-1:0] P_LAST = PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRE_FETCH,
      RD,
      WR,
      DONE
   } state_t;

   state_t                          state;
   state_t                          state_nxt;
   logic [PRE_NEUR_ADDR_WIDTH-1:0]  p;
   logic [W_WIDTH-1:0]              w;
   logic [SYN_ARRAY_ADDR_WIDTH-1:0] syn_addr;
   logic [POST_NEUR_ADDR_WIDTH-1:0] post_base;

   // Widened before the multiply so p*WORDS+w never wraps inside the datapath.
   assign syn_addr  = SYN_ARRAY_ADDR_WIDTH'(p) * SYN_ARRAY_ADDR_WIDTH'(WORDS)
                    + SYN_ARRAY_ADDR_WIDTH'(w);
   assign post_base = POST_NEUR_ADDR_WIDTH'(w) * POST_NEUR_ADDR_WIDTH'(POST_NEUR_PARALLEL);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         p     <= '0;
         w     <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               p <= '0;
               w <= '0;
            end
            WR: begin
               if (w == W_LAST) begin
                  w <= '0;
                  if (p != P_LAST) p <= p + 1'b1;
               end else begin
                  w <= w + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt                = state;
      UPD_BUSY                 = 1'b0;
      UPD_DONE                 = 1'b0;
      CTRL_SYNARRAY_CS         = 1'b0;
      CTRL_SYNARRAY_WE         = 1'b0;
      CTRL_SYNARRAY_ADDR       = '0;
      CTRL_TREF_EVENT          = 1'b0;
      CTRL_PRE_CNT_RD          = 1'b0;
      CTRL_PRE_NEURON_ADDRESS  = '0;
      CTRL_POST_CNT_RD         = 1'b0;
      CTRL_POST_NEURON_ADDRESS = '0;
      case (state)
         IDLE: begin
            if (UPD_START && IS_TRAIN && !SPI_GATE_ACTIVITY_sync) state_nxt = PRE_FETCH;
         end
         PRE_FETCH: begin
            UPD_BUSY                = 1'b1;
            CTRL_PRE_CNT_RD         = 1'b1;
            CTRL_PRE_NEURON_ADDRESS = p;
            state_nxt               = RD;
         end
         RD: begin
            UPD_BUSY                 = 1'b1;
            CTRL_SYNARRAY_CS         = 1'b1;
            CTRL_SYNARRAY_ADDR       = syn_addr;
            CTRL_POST_CNT_RD         = 1'b1;
            CTRL_POST_NEURON_ADDRESS = post_base;
            state_nxt                = WR;
         end
         WR: begin
            // p and w still hold the RD values here, so the write lands on the word just read.
            UPD_BUSY           = 1'b1;
            CTRL_SYNARRAY_CS   = 1'b1;
            CTRL_SYNARRAY_WE   = 1'b1;
            CTRL_TREF_EVENT    = 1'b1;
            CTRL_SYNARRAY_ADDR = syn_addr;
            if (w != W_LAST)      state_nxt = RD;
            else if (p != P_LAST) state_nxt = PRE_FETCH;
            else                  state_nxt = DONE;
         end
         DONE: begin
            UPD_BUSY  = 1'b1;
            UPD_DONE  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_syn_update_scheduler.sv
// Scoreboarded bench for syn_update_scheduler on a 3x8 array (2 words per pre-neuron),
// with a synaptic SRAM and an ffstdp-style update model hanging off the controls.
module tb_syn_update_scheduler;

   localparam int IN    = 3;
   localparam int ON    = 8;
   localparam int PAR   = 4;
   localparam int WORDS = 2;
   localparam int NW    = IN * WORDS;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        IS_TRAIN = 1'b0;
   logic        GATE = 1'b0;
   logic        UPD_START = 1'b0;
   logic        UPD_BUSY, UPD_DONE, CS, WE, TREF, PRE_RD, POST_RD;
   logic [15:0] ADDR;
   logic [9:0]  PRE_ADDR, POST_ADDR;

   syn_update_scheduler #(
      .INPUT_NEURON(IN), .OUTPUT_NEURON(ON), .POST_NEUR_PARALLEL(PAR),
      .SYN_ARRAY_ADDR_WIDTH(16), .PRE_NEUR_ADDR_WIDTH(10), .POST_NEUR_ADDR_WIDTH(10)
   ) dut (
      .CLK(CLK), .RST(RST), .IS_TRAIN(IS_TRAIN), .SPI_GATE_ACTIVITY_sync(GATE),
      .UPD_START(UPD_START), .UPD_BUSY(UPD_BUSY), .UPD_DONE(UPD_DONE),
      .CTRL_SYNARRAY_CS(CS), .CTRL_SYNARRAY_WE(WE), .CTRL_SYNARRAY_ADDR(ADDR),
      .CTRL_TREF_EVENT(TREF), .CTRL_PRE_CNT_RD(PRE_RD), .CTRL_PRE_NEURON_ADDRESS(PRE_ADDR),
      .CTRL_POST_CNT_RD(POST_RD), .CTRL_POST_NEURON_ADDRESS(POST_ADDR)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       cs;
      logic       we;
      logic       tref;
      logic       pre_rd;
      logic [9:0] pre_addr;
      logic       post_rd;
      logic [9:0] post_addr;
      logic [15:0] addr;
   } obs_t;

   obs_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   chk_idle = 0;
   int   we_cnt = 0, done_cnt = 0, cs_cnt = 0, busy_cnt = 0;

   // SRAM + synaptic core model
   logic [15:0] mem [0:7];
   logic [15:0] init_mem [0:7];
   int          wr_count [0:7];
   logic [3:0]  pre_cnt [0:3];
   logic [3:0]  post_cnt [0:7];
   logic [15:0] rdata;
   logic [3:0]  pre_q;
   logic [9:0]  post_q;
   int          bad_wr = 0;
   bit          load_req = 0;

   function automatic logic [15:0] ffstdp_word(logic [15:0] old, logic [3:0] pre, int base);
      logic [15:0] r;
      logic [3:0]  wt;
      r = old;
      for (int j = 0; j < PAR; j++) begin
         wt = old[4*j +: 4];
         if (pre > post_cnt[base + j] && wt != 4'hF)      wt = wt + 4'd1;
         else if (pre < post_cnt[base + j] && wt != 4'h0) wt = wt - 4'd1;
         r[4*j +: 4] = wt;
      end
      return r;
   endfunction

   always @(posedge CLK) begin
      if (load_req) begin
         for (int i = 0; i < 8; i++) begin
            mem[i]      <= init_mem[i];
            wr_count[i] <= 0;
         end
         bad_wr <= 0;
      end else begin
         if (PRE_RD) pre_q <= pre_cnt[PRE_ADDR[1:0]];
         if (POST_RD) post_q <= POST_ADDR;
         if (CS && !WE) rdata <= mem[ADDR[2:0]];
         if (WE && !(CS && TREF)) bad_wr <= bad_wr + 1;
         if (CS && WE && TREF) begin
            mem[ADDR[2:0]]      <= ffstdp_word(rdata, pre_q, int'(post_q));
            wr_count[ADDR[2:0]] <= wr_count[ADDR[2:0]] + 1;
         end
      end
   end

   task automatic monitor();
      obs_t o, e;
      forever begin
         @(negedge CLK);
         o = {UPD_BUSY, UPD_DONE, CS, WE, TREF, PRE_RD, PRE_ADDR, POST_RD, POST_ADDR, ADDR};
         if (o.we === 1'b1)   we_cnt++;
         if (o.done === 1'b1) done_cnt++;
         if (o.cs === 1'b1)   cs_cnt++;
         if (o.busy === 1'b1) busy_cnt++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL seq t=%0t got busy=%b done=%b cs=%b we=%b tref=%b prerd=%b pre=%0d postrd=%b post=%0d addr=%0d want busy=%b done=%b cs=%b we=%b tref=%b prerd=%b pre=%0d postrd=%b post=%0d addr=%0d",
                  $time, o.busy, o.done, o.cs, o.we, o.tref, o.pre_rd, o.pre_addr, o.post_rd, o.post_addr, o.addr,
                  e.busy, e.done, e.cs, e.we, e.tref, e.pre_rd, e.pre_addr, e.post_rd, e.post_addr, e.addr);
            end
         end else if (chk_idle) begin
            checks++;
            if (o !== '0) begin
               errors++;
               $display("FAIL idle t=%0t got %h want 0", $time, o);
            end
         end
      end
   endtask

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Expected per-cycle outputs starting at the start cycle; n < 0 pushes the whole sweep.
   task automatic push_sweep(int n);
      obs_t tmp[$];
      obs_t e;
      e = '0;
      tmp.push_back(e);
      for (int p = 0; p < IN; p++) begin
         e = '0; e.busy = 1; e.pre_rd = 1; e.pre_addr = 10'(p);
         tmp.push_back(e);
         for (int w = 0; w < WORDS; w++) begin
            e = '0; e.busy = 1; e.cs = 1; e.post_rd = 1;
            e.post_addr = 10'(w * PAR); e.addr = 16'(p * WORDS + w);
            tmp.push_back(e);
            e.post_rd = 0; e.post_addr = '0; e.we = 1; e.tref = 1;
            tmp.push_back(e);
         end
      end
      e = '0; e.busy = 1; e.done = 1;
      tmp.push_back(e);
      if (n < 0) n = tmp.size();
      for (int i = 0; i < n; i++) exp_q.push_back(tmp[i]);
   endtask

   task automatic wait_done(string name, int want);
      int n = 1;
      while (UPD_DONE !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (n != want) begin
         errors++;
         $display("FAIL %s_done_latency got %0d want %0d", name, n, want);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      tick(3);
      chk_idle = 1;
      checks++;
      if ({UPD_BUSY, UPD_DONE, CS, WE, TREF, PRE_RD, PRE_ADDR, POST_RD, POST_ADDR, ADDR} !== 43'd0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b cs=%b we=%b addr=%0d want all 0", UPD_BUSY, CS, WE, ADDR);
      end
      RST = 1'b0;
      tick(2);
   endtask

   task automatic test_sweep_timing();
      int d0 = done_cnt;
      IS_TRAIN = 1'b1;
      UPD_START = 1'b1;
      push_sweep(-1);
      tick();
      UPD_START = 1'b0;
      wait_done("timing", 1 + IN * (1 + 2 * WORDS));
      tick(3);
      checks++;
      if (exp_q.size() != 0 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL timing_tail got left=%0d dones=%0d want 0 and 1", exp_q.size(), done_cnt - d0);
      end
   endtask

   task automatic test_no_start();
      int b0, c0;
      for (int k = 0; k < 2; k++) begin
         b0 = busy_cnt; c0 = cs_cnt;
         IS_TRAIN = (k == 1);
         GATE     = (k == 1);
         UPD_START = 1'b1;
         tick();
         UPD_START = 1'b0;
         tick(20);
         checks++;
         if (busy_cnt != b0 || cs_cnt != c0) begin
            errors++;
            $display("FAIL no_start_%0d got busy_cycles=%0d cs_cycles=%0d want 0 and 0", k, busy_cnt - b0, cs_cnt - c0);
         end
      end
      IS_TRAIN = 1'b1;
      GATE = 1'b0;
   endtask

   task automatic test_ignored_start();
      int d0 = done_cnt;
      int w0 = we_cnt;
      UPD_START = 1'b1;
      push_sweep(-1);
      tick();
      UPD_START = 1'b0;
      tick(4);
      UPD_START = 1'b1;
      tick();
      UPD_START = 1'b0;
      tick(10);
      UPD_START = 1'b1;
      tick();
      UPD_START = 1'b0;
      tick(6);
      checks++;
      if (done_cnt - d0 != 1 || we_cnt - w0 != NW) begin
         errors++;
         $display("FAIL ignored_start got dones=%0d writes=%0d want 1 and %0d", done_cnt - d0, we_cnt - w0, NW);
      end
   endtask

   task automatic test_reset_mid();
      int d0, w0;
      UPD_START = 1'b1;
      push_sweep(9);
      tick();
      UPD_START = 1'b0;
      tick(7);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      d0 = done_cnt; w0 = we_cnt;
      tick(3);
      checks++;
      if (done_cnt != d0 || we_cnt != w0) begin
         errors++;
         $display("FAIL reset_abort got dones=%0d writes=%0d want 0 and 0", done_cnt - d0, we_cnt - w0);
      end
      UPD_START = 1'b1;
      push_sweep(-1);
      tick();
      UPD_START = 1'b0;
      checks++;
      if (PRE_RD !== 1'b1 || PRE_ADDR !== 10'd0) begin
         errors++;
         $display("FAIL restart_prefetch got rd=%b p=%0d want 1 and 0", PRE_RD, PRE_ADDR);
      end
      wait_done("restart", 1 + IN * (1 + 2 * WORDS));
      tick(3);
   endtask

   task automatic test_full_sweep();
      logic [15:0] gold [0:7];
      for (int i = 0; i < 8; i++) begin
         init_mem[i] = 16'($urandom);
         post_cnt[i] = 4'($urandom_range(0, 7));
      end
      for (int i = 0; i < 4; i++) pre_cnt[i] = 4'($urandom_range(0, 7));
      for (int p = 0; p < IN; p++)
         for (int w = 0; w < WORDS; w++)
            gold[p * WORDS + w] = ffstdp_word(init_mem[p * WORDS + w], pre_cnt[p], w * PAR);
      for (int i = NW; i < 8; i++) gold[i] = init_mem[i];
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      UPD_START = 1'b1;
      push_sweep(-1);
      tick();
      UPD_START = 1'b0;
      tick(2);
      IS_TRAIN = 1'b0;
      GATE = 1'b1;
      wait_done("full", 1 + IN * (1 + 2 * WORDS) - 2);
      tick(2);
      for (int i = 0; i < NW; i++) begin
         checks++;
         if (mem[i] !== gold[i]) begin
            errors++;
            $display("FAIL word_%0d got %h want %h", i, mem[i], gold[i]);
         end
         checks++;
         if (wr_count[i] != 1) begin
            errors++;
            $display("FAIL writes_%0d got %0d want 1", i, wr_count[i]);
         end
      end
      checks++;
      if (bad_wr != 0) begin
         errors++;
         $display("FAIL wr_qualifier got %0d bad writes want 0", bad_wr);
      end
      IS_TRAIN = 1'b1;
      GATE = 1'b0;
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_sweep_timing();
      test_no_start();
      test_ignored_start();
      test_reset_mid();
      test_full_sweep();
      tick(2);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/syn_update_scheduler.md
SYN_UPDATE_SCHEDULER -- requirements
Module: syn_update_scheduler

Interface
REQ-001 SHALL have parameter INPUT_NEURON, default 784, number of pre-synaptic neurons.
REQ-002 SHALL have parameter OUTPUT_NEURON, default 256, number of post-synaptic neurons.
REQ-003 SHALL have parameter POST_NEUR_PARALLEL, default 4, weights per synaptic SRAM word.
REQ-004 SHALL have parameter SYN_ARRAY_ADDR_WIDTH, default 16, synaptic SRAM address width.
REQ-005 SHALL have parameters PRE_NEUR_ADDR_WIDTH and POST_NEUR_ADDR_WIDTH, both default 10, neuron address widths.
REQ-006 SHALL have port CLK  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-008 SHALL have port IS_TRAIN  in  1  training mode enable.
REQ-009 SHALL have port SPI_GATE_ACTIVITY_sync  in  1  configuration gate; high blocks new sweeps.
REQ-010 SHALL have port UPD_START  in  1  single-cycle sweep request.
REQ-011 SHALL have port UPD_BUSY  out  1  high from the cycle after an accepted start through the DONE cycle.
REQ-012 SHALL have port UPD_DONE  out  1  single-cycle sweep-complete pulse.
REQ-013 SHALL have ports CTRL_SYNARRAY_CS and CTRL_SYNARRAY_WE  out  1 each  synaptic SRAM chip select and write enable.
REQ-014 SHALL have port CTRL_SYNARRAY_ADDR  out  SYN_ARRAY_ADDR_WIDTH  synaptic SRAM word address.
REQ-015 SHALL have port CTRL_TREF_EVENT  out  1  weight-update qualifier to the synaptic core.
REQ-016 SHALL have ports CTRL_PRE_CNT_RD  out  1 and CTRL_PRE_NEURON_ADDRESS  out  PRE_NEUR_ADDR_WIDTH  pre spike-count read request and address.
REQ-017 SHALL have ports CTRL_POST_CNT_RD  out  1 and CTRL_POST_NEURON_ADDRESS  out  POST_NEUR_ADDR_WIDTH  post spike-count read request and base address.

Function
REQ-018 SHALL define WORDS = OUTPUT_NEURON/POST_NEUR_PARALLEL (64 by default).
REQ-019 SHALL implement an FSM with states IDLE, PRE_FETCH, RD, WR and DONE.
REQ-020 SHALL transition IDLE->PRE_FETCH only when UPD_START=1, IS_TRAIN=1 and SPI_GATE_ACTIVITY_sync=0; UPD_START SHALL otherwise be ignored with no effect.
REQ-021 SHALL ignore UPD_START in every state except IDLE.
REQ-022 SHALL in PRE_FETCH assert CTRL_PRE_CNT_RD for exactly 1 cycle with CTRL_PRE_NEURON_ADDRESS=p, then go to RD with w=0.
REQ-023 SHALL in RD assert CS=1, WE=0, ADDR=p*WORDS+w, CTRL_POST_CNT_RD=1 and CTRL_POST_NEURON_ADDRESS=w*POST_NEUR_PARALLEL, then go to WR.
REQ-024 SHALL in WR assert CS=1, WE=1, CTRL_TREF_EVENT=1 and hold ADDR equal to the preceding RD address, since read data and write data follow one-cycle SRAM read latency.
REQ-025 SHALL leave WR for RD with w+1 if w<WORDS-1, for PRE_FETCH with p+1 and w=0 if w=WORDS-1 and p<INPUT_NEURON-1, and for DONE otherwise.
REQ-026 SHALL in DONE assert UPD_DONE=1 for 1 cycle and return to IDLE.
REQ-027 SHALL compute the address as p*WORDS+w without truncation; INPUT_NEURON*WORDS SHALL NOT exceed 2^SYN_ARRAY_ADDR_WIDTH.
REQ-028 SHALL keep CS, WE, CTRL_TREF_EVENT, CTRL_PRE_CNT_RD and CTRL_POST_CNT_RD low in IDLE and DONE, and SHALL keep CS, WE and CTRL_TREF_EVENT low in PRE_FETCH.
REQ-029 SHALL take 1+INPUT_NEURON*(1+2*WORDS) cycles from the accepted-start cycle to UPD_DONE; this is 101137 cycles at defaults.
REQ-030 SHALL ignore IS_TRAIN and SPI_GATE_ACTIVITY_sync changes mid-sweep and complete the sweep.
REQ-031 SHALL drive all outputs from registers or from state-decoded logic, with no combinational path from inputs to outputs.

Reset
REQ-032 SHALL on RST=1 at a clock edge enter IDLE, clear p and w, and drive every output to 0 in the following cycle.
REQ-033 SHALL on reset asserted mid-sweep abort without a further write and without UPD_DONE; a new UPD_START SHALL restart the sweep at p=0, w=0.

Verification (INPUT_NEURON=3, OUTPUT_NEURON=8, POST_NEUR_PARALLEL=4, WORDS=2)
REQ-034 SHALL cover: UPD_START with IS_TRAIN=1 at cycle 0 -> PRE_FETCH p=0 at cycle 1, RD addr 0/1 at cycles 2/4, WR addr 0/1 at cycles 3/5, PRE_FETCH p=1 at cycle 6, last WR addr 5 at cycle 15, UPD_DONE at cycle 16.
REQ-035 SHALL cover: UPD_START with IS_TRAIN=0, or with SPI_GATE_ACTIVITY_sync=1 -> UPD_BUSY stays 0 and CS stays 0 for 20 cycles.
REQ-036 SHALL cover: UPD_START repulsed at cycles 5 and 16 -> exactly one sweep and exactly one UPD_DONE.
REQ-037 SHALL cover: RST at cycle 8 -> outputs 0 from cycle 9 with no WE and no UPD_DONE; UPD_START at cycle 12 -> PRE_FETCH p=0 at cycle 13.
REQ-038 SHALL cover: a full sweep with an SRAM model and an ffstdp_update golden model -> every word is written exactly once, and each WR asserts CTRL_TREF_EVENT with CS=WE=1.
